seg_display_bank: RTL and testbench
===================================

// Module: seg_display_bank
// PURPOSE
//  Registered multi-digit seven-segment display bank, the successor to single-digit combinational decoding.
//  Holds NUM_DIGITS 5-bit digit codes and supports addressed writes, shift-in pushes, clear and per-digit blink.
//  Drives every digit's active-low segments in parallel to the board HEX displays.
//  Processor MMIO and game-state logic use it to show squares and moves, e.g. "A3-B4".
// PARAMETERS
//  NUM_DIGITS  4           number of displayed digits, 1..8
//  BLINK_DIV   25_000_000  clock cycles per blink half-period, >=2
// PORTS
//  clock          in   1             system clock, single domain
//  reset          in   1             synchronous, active-high
//  wr_en          in   1             addressed write strobe
//  wr_addr        in   3             digit index, 0 = rightmost
//  wr_data        in   5             digit code for addressed write
//  push_en        in   1             shift-in strobe
//  push_data      in   5             code entering digit 0 on push
//  clear          in   1             blank all digits
//  blink_wr       in   1             load blink mask
//  blink_mask_in  in   NUM_DIGITS    1 = digit blinks
//  seg_out        out  7*NUM_DIGITS  digit i on [7i+6:7i], active-low {g,f,e,d,c,b,a}
//  blink_phase    out  1             current blink phase, 1 = blinked digits dark
// BEHAVIOUR
//  - Clock is clock. Reset is synchronous and active-high: sampled on the rising edge of clock only.
//  - Reset: all codes = 17 (blank), blink mask = 0, blink counter = 0, blink_phase = 0, seg_out = all 1s.
//  - Code map:
//    - 0..8 -> digits 0..8: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000.
//    - 9..16 -> A..H: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110, 1000010, 0001001.
//    - 18 -> dash, 0111111.
//    - 17 and 19..31 -> blank, 1111111.
//  - Update priority in one cycle: clear > push_en > wr_en. Only the highest-priority asserted strobe acts.
//  - wr_en: code[wr_addr] <= wr_data. If wr_addr >= NUM_DIGITS the write is dropped and no state changes.
//  - push_en: code[i] <= code[i-1] for i >= 1, code[0] <= push_data. code[NUM_DIGITS-1] is discarded.
//  - clear: all codes <= 17. Blink mask, counter and phase are unaffected.
//  - blink_wr acts independently of the code strobes and may occur in the same cycle: mask <= blink_mask_in.
//  - Latency: a strobe sampled at edge k updates its code register at edge k. seg_out reflects it after edge k+1.
//    seg_out is a registered output: decode happens between the code and output registers.
//  - Blink counter counts 0..BLINK_DIV-1 and then wraps to 0. On the wrap, blink_phase toggles.
//    seg_out uses the registered blink_phase, so it follows a phase toggle one cycle later.
//  - Digit i is forced to 1111111 iff mask[i] and blink_phase are both 1. Its stored code is unaffected.
//  - Reset asserted mid-operation or mid-blink overrides every strobe in that cycle and restores all reset values.
// CONFIGURATION
//  - SEG_BLINK_EN defined:
//    - Blink counter, blink mask and blink_phase are implemented as described above.
//  - SEG_BLINK_EN undefined:
//    - No counter and no mask registers. blink_phase is tied to 0. blink_wr and blink_mask_in are ignored.
//    - seg_out depends on the codes only.
//    - Ports are identical in both builds.
// TESTING  (NUM_DIGITS=4, BLINK_DIV=4, SEG_BLINK_EN defined unless noted)
//  - Release reset -> seg_out = 28'hFFFFFFF, blink_phase = 0.
//  - wr_en, addr 0, data 9 -> two edges later seg_out[6:0] = 0001000 (A); other digits stay 1111111.
//  - push 10, 3, 18 on consecutive cycles -> digits[2:0] = B, 3, dash; digit 3 stays blank.
//    Then one more push of 5 -> digits[3:0] = B, 3, dash, 5.
//  - clear, push_en and wr_en all asserted together -> all digits blank. The push and the write have no effect.
//  - wr_en with addr 5 -> no code changes. Sweep codes 0..31 into digit 0 -> check the map, 19..31 blank.
//  - blink_wr with mask 0001 and digit 0 = 4:
//    - blink_phase toggles every 4 cycles.
//    - seg_out[6:0] alternates 0011001 / 1111111.
//    - Reset mid-blink -> mask 0 and phase 0.
//    - Rebuild without SEG_BLINK_EN -> no alternation, blink_phase stays 0.

Source files
------------

// File: rtl/seg_display_bank.sv
// Registered seven-segment display bank: NUM_DIGITS 5-bit codes with write, push and clear.
// Per-digit blink exists only when SEG_BLINK_EN is defined; otherwise blink_phase is tied to 0.
module seg_display_bank #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [2:0]              wr_addr,
  input  logic [4:0]              wr_data,
  input  logic                    push_en,
  input  logic [4:0]              push_data,
  input  logic                    clear,
  input  logic                    blink_wr,
  input  logic [NUM_DIGITS-1:0]   blink_mask_in,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    blink_phase
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEG_W  = 7;
  localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(17);

  logic [CODE_W-1:0]           r_code [NUM_DIGITS];
  logic [SEG_W*NUM_DIGITS-1:0] r_seg;
  logic [NUM_DIGITS-1:0]       w_dark;

  // Active-low {g,f,e,d,c,b,a} pattern for one digit code.
  function automatic logic [SEG_W-1:0] f_decode(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] seg;
    seg = 7'b1111111;
    case (code)
      5'd0:  seg = 7'b1000000;
      5'd1:  seg = 7'b1111001;
      5'd2:  seg = 7'b0100100;
      5'd3:  seg = 7'b0110000;
      5'd4:  seg = 7'b0011001;
      5'd5:  seg = 7'b0010010;
      5'd6:  seg = 7'b0000010;
      5'd7:  seg = 7'b1111000;
      5'd8:  seg = 7'b0000000;
      5'd9:  seg = 7'b0001000;
      5'd10: seg = 7'b0000011;
      5'd11: seg = 7'b1000110;
      5'd12: seg = 7'b0100001;
      5'd13: seg = 7'b0000110;
      5'd14: seg = 7'b0001110;
      5'd15: seg = 7'b1000010;
      5'd16: seg = 7'b0001001;
      5'd18: seg = 7'b0111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Code registers: clear beats push beats addressed write.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) r_code[i] <= CODE_BLANK;
    end else if (push_en) begin
      r_code[0] <= push_data;
      for (int i = 1; i < int'(NUM_DIGITS); i++) r_code[i] <= r_code[i-1];
    end else if (wr_en) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (wr_addr == 3'(i)) r_code[i] <= wr_data;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_DIGITS-1:0] r_mask;
  logic                  r_phase;

  // Free-running half-period counter; phase flips on each wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_mask  <= '0;
      r_phase <= 1'b0;
    end else begin
      if (blink_wr) r_mask <= blink_mask_in;
      if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_dark      = r_phase ? r_mask : '0;
  assign blink_phase = r_phase;
`else
  logic w_unused_blink;

  assign w_unused_blink = ^{blink_wr, blink_mask_in, 32'(BLINK_DIV)};
  assign w_dark         = '0;
  assign blink_phase    = 1'b0;
`endif

  // Output register: decode stage between code registers and the pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seg <= '1;
    end else begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        r_seg[SEG_W*i +: SEG_W] <= w_dark[i] ? 7'b1111111 : f_decode(r_code[i]);
      end
    end
  end

  assign seg_out = r_seg;

endmodule

// File: tb/tb_seg_display_bank.sv
// Randomized bench for seg_display_bank against a cycle-count based reference model.
module tb_seg_display_bank;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 4;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [4:0]    wr_data = '0;
  logic          push_en = 1'b0;
  logic [4:0]    push_data = '0;
  logic          clear = 1'b0;
  logic          blink_wr = 1'b0;
  logic [ND-1:0] blink_mask_in = '0;
  logic [7*ND-1:0] seg_out;
  logic          blink_phase;

  int n_total = 0;
  int n_pass  = 0;

  seg_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .push_en(push_en), .push_data(push_data), .clear(clear), .blink_wr(blink_wr),
    .blink_mask_in(blink_mask_in), .seg_out(seg_out), .blink_phase(blink_phase)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Segment table straight from the code map.
  logic [6:0] seg_tab [32];
  initial begin
    for (int c = 0; c < 32; c++) seg_tab[c] = 7'b1111111;
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0001000; seg_tab[10] = 7'b0000011; seg_tab[11] = 7'b1000110;
    seg_tab[12] = 7'b0100001; seg_tab[13] = 7'b0000110; seg_tab[14] = 7'b0001110;
    seg_tab[15] = 7'b1000010; seg_tab[16] = 7'b0001001; seg_tab[18] = 7'b0111111;
  end

  // Model state: digit codes, mask, and edges elapsed since the last reset.
  int         m_code [ND];
  logic [ND-1:0] m_mask;
  int         m_n;
  bit         m_valid = 1'b0;
  logic [27:0] exp_seg;
  logic       exp_phase;

  function automatic bit phase_of(input int n);
    return BLINK && (((n / int'(DIV)) % 2) == 1);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      exp_seg = '1;
      for (int d = 0; d < int'(ND); d++) m_code[d] = 17;
      m_mask  = '0;
      m_n     = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int d = 0; d < int'(ND); d++)
        exp_seg[7*d +: 7] = (m_mask[d] && phase_of(m_n)) ? 7'b1111111 : seg_tab[m_code[d]];
      if (clear) begin
        for (int d = 0; d < int'(ND); d++) m_code[d] = 17;
      end else if (push_en) begin
        for (int d = int'(ND) - 1; d > 0; d--) m_code[d] = m_code[d-1];
        m_code[0] = int'(push_data);
      end else if (wr_en && int'(wr_addr) < int'(ND)) begin
        m_code[int'(wr_addr)] = int'(wr_data);
      end
      if (BLINK && blink_wr) m_mask = blink_mask_in;
      m_n++;
    end
    exp_phase = phase_of(m_n);
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("seg_out_model", seg_out, exp_seg);
      check("blink_phase_model", {27'b0, blink_phase}, {27'b0, exp_phase});
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    wr_en = 0; push_en = 0; clear = 0; blink_wr = 0; reset = 0;
  endtask

  initial begin
    int toggles, dark, lit;
    logic prev;
    logic [27:0] v;

    reset = 1; tick; tick; reset = 0;
    check("reset_seg", seg_out, 28'hFFFFFFF);
    check("reset_phase", {27'b0, blink_phase}, 28'h0);

    wr_en = 1; wr_addr = 0; wr_data = 9; tick; idle; tick;
    check("write_A_digit0", seg_out, 28'hFFFFF88);

    clear = 1; tick; idle;
    push_en = 1;
    push_data = 10; tick;
    push_data = 3;  tick;
    push_data = 18; tick;
    idle; tick;
    v = {7'b1111111, 7'b0000011, 7'b0110000, 7'b0111111};
    check("push_B_3_dash", seg_out, v);
    push_en = 1; push_data = 5; tick; idle; tick;
    v = {7'b0000011, 7'b0110000, 7'b0111111, 7'b0010010};
    check("push_5_shift", seg_out, v);

    clear = 1; push_en = 1; push_data = 1; wr_en = 1; wr_addr = 1; wr_data = 2; tick; idle; tick;
    check("clear_priority", seg_out, 28'hFFFFFFF);

    wr_en = 1; wr_addr = 5; wr_data = 0; tick; idle; tick;
    check("write_addr5_dropped", seg_out, 28'hFFFFFFF);

    for (int c = 0; c < 32; c++) begin
      wr_en = 1; wr_addr = 0; wr_data = 5'(c); tick;
    end
    idle; tick;
    check("sweep_last_31_blank", seg_out, 28'hFFFFFFF);
    wr_en = 1; wr_addr = 0; wr_data = 7; tick; idle; tick;
    check("code7", {21'b0, seg_out[6:0]}, {21'b0, 7'b1111000});
    wr_en = 1; wr_addr = 0; wr_data = 16; tick; idle; tick;
    check("code16_H", {21'b0, seg_out[6:0]}, {21'b0, 7'b0001001});
    wr_en = 1; wr_addr = 0; wr_data = 25; tick; idle; tick;
    check("code25_blank", {21'b0, seg_out[6:0]}, {21'b0, 7'b1111111});

    wr_en = 1; wr_addr = 0; wr_data = 4; blink_wr = 1; blink_mask_in = 4'b0001; tick; idle;
    tick; tick;
    toggles = 0; dark = 0; lit = 0; prev = blink_phase;
    for (int k = 0; k < 16; k++) begin
      tick;
      if (blink_phase !== prev) toggles++;
      prev = blink_phase;
      if (seg_out[6:0] === 7'b1111111) dark++;
      if (seg_out[6:0] === 7'b0011001) lit++;
    end
    check("phase_toggles_16cyc", 28'(toggles), BLINK ? 28'd4 : 28'd0);
    check("blink_dark_count", 28'(dark), BLINK ? 28'd8 : 28'd0);
    check("blink_total_count", 28'(dark + lit), 28'd16);

    for (int k = 0; k < 5; k++) tick;
    reset = 1; tick; idle;
    check("midblink_reset_seg", seg_out, 28'hFFFFFFF);
    check("midblink_reset_phase", {27'b0, blink_phase}, 28'h0);
    wr_en = 1; wr_addr = 0; wr_data = 4; tick; idle; tick;
    dark = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (seg_out[6:0] !== 7'b0011001) dark++;
    end
    check("mask_cleared_by_reset", 28'(dark), 28'd0);

    for (int k = 0; k < 600; k++) begin
      clear         = ($urandom_range(99) < 4);
      push_en       = ($urandom_range(99) < 30);
      push_data     = 5'($urandom);
      wr_en         = ($urandom_range(99) < 45);
      wr_addr       = 3'($urandom);
      wr_data       = 5'($urandom);
      blink_wr      = ($urandom_range(99) < 8);
      blink_mask_in = 4'($urandom);
      reset         = ($urandom_range(199) < 2);
      tick;
    end
    idle; tick; tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
